spec_peak_finder: RTL and testbench

SPEC_PEAK_FINDER -- requirements
Module: spec_peak_finder

---
 rtl/spec_peak_finder_pkg.sv | 32 +++
 rtl/spec_peak_finder_peak_insert.sv | 75 +++++++
 rtl/spec_peak_finder.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_spec_peak_finder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/spec_peak_finder_pkg.sv
// -----------------------------------------------------------------------------
// spec_pkg
// Shared definitions for the spectral peak finder:
//   - state_e       : controller states (IDLE, SCAN, FLUSH, HARM, DONE)
//   - DEF_DATA_W    : default magnitude width
//   - DEF_ADDR_W    : default RAM address width (N_BINS = 2**ADDR_W)
//   - DEF_N_PEAKS   : default number of peak slots
//   - harm_addr()   : third-harmonic bin index, 3*bin, two bits wider than the
//                     address so the product never wraps
// -----------------------------------------------------------------------------
package spec_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_N_PEAKS = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_HARM  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // 3*bin computed as (bin<<1)+bin on a widened operand.
    function automatic logic [DEF_ADDR_W+1:0] harm_addr(input logic [DEF_ADDR_W-1:0] bin);
        logic [DEF_ADDR_W+1:0] b_ext;
        b_ext = {2'b00, bin};
        return (b_ext << 1) + b_ext;
    endfunction

endpackage

// File: rtl/spec_peak_finder_peak_insert.sv
// -----------------------------------------------------------------------------
// peak_insert
// Combinational sorted insert of one (bin, mag) candidate into a peak list
// kept in descending magnitude order. A candidate lands below every existing
// entry of equal or larger magnitude, so on a tie the earlier (lower) bin keeps
// its rank. Whatever is pushed past the last slot falls off the end.
// Ports:
//   in_bin / in_mag   : current list, slot 0 in the LSBs
//   in_cnt            : number of filled slots
//   ins_bin / ins_mag : candidate
//   out_bin / out_mag : list after insertion
//   out_cnt           : filled slots after insertion (saturates at N_PEAKS)
// -----------------------------------------------------------------------------
module peak_insert
    import spec_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int N_PEAKS = DEF_N_PEAKS
) (
    input  logic [N_PEAKS*ADDR_W-1:0] in_bin,
    input  logic [N_PEAKS*DATA_W-1:0] in_mag,
    input  logic [2:0]                in_cnt,
    input  logic [ADDR_W-1:0]         ins_bin,
    input  logic [DATA_W-1:0]         ins_mag,
    output logic [N_PEAKS*ADDR_W-1:0] out_bin,
    output logic [N_PEAKS*DATA_W-1:0] out_mag,
    output logic [2:0]                out_cnt
);

    int pos;

    // Locate the insertion slot, then rebuild the list around it.
    always_comb begin
        pos = 0;
        for (int i = 0; i < N_PEAKS; i++) begin
            if ((i < int'(in_cnt)) && (in_mag[i*DATA_W +: DATA_W] >= ins_mag)) begin
                pos = pos + 1;
            end else begin
                pos = pos;
            end
        end

        out_bin = in_bin;
        out_mag = in_mag;

        if (pos == 0) begin
            out_bin[ADDR_W-1:0] = ins_bin;
            out_mag[DATA_W-1:0] = ins_mag;
        end else begin
            out_bin[ADDR_W-1:0] = in_bin[ADDR_W-1:0];
            out_mag[DATA_W-1:0] = in_mag[DATA_W-1:0];
        end

        for (int i = 1; i < N_PEAKS; i++) begin
            if (i < pos) begin
                out_bin[i*ADDR_W +: ADDR_W] = in_bin[i*ADDR_W +: ADDR_W];
                out_mag[i*DATA_W +: DATA_W] = in_mag[i*DATA_W +: DATA_W];
            end else if (i == pos) begin
                out_bin[i*ADDR_W +: ADDR_W] = ins_bin;
                out_mag[i*DATA_W +: DATA_W] = ins_mag;
            end else begin
                out_bin[i*ADDR_W +: ADDR_W] = in_bin[(i-1)*ADDR_W +: ADDR_W];
                out_mag[i*DATA_W +: DATA_W] = in_mag[(i-1)*DATA_W +: DATA_W];
            end
        end

        if (int'(in_cnt) < N_PEAKS) begin
            out_cnt = in_cnt + 3'd1;
        end else begin
            out_cnt = in_cnt;
        end
    end

endmodule

// File: rtl/spec_peak_finder.sv
// -----------------------------------------------------------------------------
// spec_peak_finder
// Scans the lower half of a magnitude spectrum held in an external RAM, keeps
// the N_PEAKS largest local maxima, then reads each peak's third harmonic to
// classify it as sine (weak harmonic) or triangle (strong harmonic).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : rising edge launches a scan (ignored unless idle)
//   clr        : level; aborts any scan and clears all results
//   rd_addr    : magnitude RAM read address
//   rd_data    : magnitude returned RD_LAT cycles after rd_addr
//   peak_bin   : packed bin indices, slot 0 in the LSBs
//   peak_mag   : packed peak magnitudes
//   peak_sin   : per slot, 1 = sine, 0 = triangle
//   peak_cnt   : number of filled slots
//   busy       : scan in progress
//   valid      : results posted and stable
// -----------------------------------------------------------------------------
module spec_peak_finder
    import spec_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                N_PEAKS    = DEF_N_PEAKS,
    parameter int                BIN_MIN    = 1,
    parameter int                RD_LAT     = 1,
    parameter int                HARM_SHIFT = 5,
    parameter logic [DATA_W-1:0] THRESH     = 16'd64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      clr,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [DATA_W-1:0]         rd_data,
    output logic [N_PEAKS*ADDR_W-1:0] peak_bin,
    output logic [N_PEAKS*DATA_W-1:0] peak_mag,
    output logic [N_PEAKS-1:0]        peak_sin,
    output logic [2:0]                peak_cnt,
    output logic                      busy,
    output logic                      valid
);

    localparam int                HALF      = 1 << (ADDR_W - 1);
    localparam logic [ADDR_W-1:0] HALF_A    = ADDR_W'(HALF);
    localparam logic [ADDR_W+1:0] HALF_H    = (ADDR_W + 2)'(HALF);
    localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(BIN_MIN - 1);
    // First returned address whose window centre (address-1) is eligible.
    localparam logic [ADDR_W-1:0] FIRST_K_A = ADDR_W'(BIN_MIN + 1);
    localparam logic [1:0]        LAT_LAST  = 2'(RD_LAT);

    state_e                    state_q, state_d;
    logic                      start_d_q, start_d_d;
    logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
    logic [RD_LAT-1:0]         tag_vld_q, tag_vld_d;
    logic [ADDR_W-1:0]         tag_addr_q [RD_LAT];
    logic [ADDR_W-1:0]         tag_addr_d [RD_LAT];
    logic [DATA_W-1:0]         prev_q, prev_d;
    logic [DATA_W-1:0]         cur_q, cur_d;
    logic [1:0]                flush_cnt_q, flush_cnt_d;
    logic [N_PEAKS*ADDR_W-1:0] list_bin_q, list_bin_d;
    logic [N_PEAKS*DATA_W-1:0] list_mag_q, list_mag_d;
    logic [N_PEAKS-1:0]        list_sin_q, list_sin_d;
    logic [2:0]                list_cnt_q, list_cnt_d;
    logic [2:0]                hidx_q, hidx_d;
    logic [1:0]                hw_q, hw_d;
    logic [N_PEAKS*ADDR_W-1:0] peak_bin_q, peak_bin_d;
    logic [N_PEAKS*DATA_W-1:0] peak_mag_q, peak_mag_d;
    logic [N_PEAKS-1:0]        peak_sin_q, peak_sin_d;
    logic [2:0]                peak_cnt_q, peak_cnt_d;
    logic                      busy_q, busy_d;
    logic                      valid_q, valid_d;

    logic                      start_edge_s;
    logic                      tv_s;
    logic [ADDR_W-1:0]         ta_s;
    logic                      ins_en_s;
    logic [ADDR_W-1:0]         ins_bin_s;
    logic [N_PEAKS*ADDR_W-1:0] ins_list_bin_s;
    logic [N_PEAKS*DATA_W-1:0] ins_list_mag_s;
    logic [2:0]                ins_list_cnt_s;
    logic [ADDR_W-1:0]         slot_bin_s, next_bin_s;
    logic [DATA_W-1:0]         slot_mag_s;
    logic [ADDR_W+1:0]         slot_h_s, next_h_s, first_h_s;
    logic                      slot_skip_s;
    logic                      harm_sin_s;

    // Data returning from the RAM belongs to the oldest tagged scan address.
    assign tv_s      = tag_vld_q[RD_LAT-1];
    assign ta_s      = tag_addr_q[RD_LAT-1];
    assign ins_bin_s = ta_s - {{(ADDR_W-1){1'b0}}, 1'b1};
    // Window is (prev, cur, rd_data) centred on bin ta_s-1.
    assign ins_en_s  = tv_s && (ta_s >= FIRST_K_A) && (cur_q > prev_q)
                       && (cur_q >= rd_data) && (cur_q >= THRESH);
    assign start_edge_s = start && !start_d_q;

    peak_insert #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .N_PEAKS (N_PEAKS)
    ) u_peak_insert (
        .in_bin  (list_bin_q),
        .in_mag  (list_mag_q),
        .in_cnt  (list_cnt_q),
        .ins_bin (ins_bin_s),
        .ins_mag (cur_q),
        .out_bin (ins_list_bin_s),
        .out_mag (ins_list_mag_s),
        .out_cnt (ins_list_cnt_s)
    );

    // Select the slot being classified and the one after it.
    always_comb begin
        slot_bin_s = '0;
        slot_mag_s = '0;
        next_bin_s = '0;
        for (int i = 0; i < N_PEAKS; i++) begin
            if (3'(i) == hidx_q) begin
                slot_bin_s = list_bin_q[i*ADDR_W +: ADDR_W];
                slot_mag_s = list_mag_q[i*DATA_W +: DATA_W];
            end else begin
                slot_bin_s = slot_bin_s;
            end
            if (3'(i) == (hidx_q + 3'd1)) begin
                next_bin_s = list_bin_q[i*ADDR_W +: ADDR_W];
            end else begin
                next_bin_s = next_bin_s;
            end
        end
        slot_h_s    = harm_addr(slot_bin_s);
        next_h_s    = harm_addr(next_bin_s);
        first_h_s   = harm_addr(list_bin_q[ADDR_W-1:0]);
        slot_skip_s = (slot_h_s >= HALF_H);
        harm_sin_s  = slot_skip_s ? 1'b1 : !(rd_data > (slot_mag_s >> HARM_SHIFT));
    end

    // Next-state logic for the controller, scan pipeline and result registers.
    always_comb begin
        state_d     = state_q;
        start_d_d   = start;
        rd_addr_d   = rd_addr_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        flush_cnt_d = flush_cnt_q;
        list_bin_d  = list_bin_q;
        list_mag_d  = list_mag_q;
        list_sin_d  = list_sin_q;
        list_cnt_d  = list_cnt_q;
        hidx_d      = hidx_q;
        hw_d        = hw_q;
        peak_bin_d  = peak_bin_q;
        peak_mag_d  = peak_mag_q;
        peak_sin_d  = peak_sin_q;
        peak_cnt_d  = peak_cnt_q;
        busy_d      = busy_q;
        valid_d     = valid_q;

        // Tag pipeline mirrors the RAM latency for scan reads only.
        tag_vld_d[0]  = (state_q == ST_SCAN);
        tag_addr_d[0] = rd_addr_q;
        for (int j = 1; j < RD_LAT; j++) begin
            tag_vld_d[j]  = tag_vld_q[j-1];
            tag_addr_d[j] = tag_addr_q[j-1];
        end

        // Slide the window and fold any detected peak into the list.
        if (tv_s) begin
            prev_d = cur_q;
            cur_d  = rd_data;
            if (ins_en_s) begin
                list_bin_d = ins_list_bin_s;
                list_mag_d = ins_list_mag_s;
                list_cnt_d = ins_list_cnt_s;
            end else begin
                list_cnt_d = list_cnt_q;
            end
        end else begin
            prev_d = prev_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_d    = ST_SCAN;
                    rd_addr_d  = START_A;
                    busy_d     = 1'b1;
                    valid_d    = 1'b0;
                    list_bin_d = '0;
                    list_mag_d = '0;
                    list_sin_d = '0;
                    list_cnt_d = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (rd_addr_q == HALF_A) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = 2'd0;
                end else begin
                    rd_addr_d = rd_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_FLUSH: begin
                // The list is final once the pipeline has drained; arm slot 0.
                if (flush_cnt_q == LAT_LAST) begin
                    hidx_d = 3'd0;
                    hw_d   = 2'd0;
                    if (list_cnt_q == 3'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_HARM;
                        if (first_h_s < HALF_H) begin
                            rd_addr_d = first_h_s[ADDR_W-1:0];
                        end else begin
                            rd_addr_d = rd_addr_q;
                        end
                    end
                end else begin
                    flush_cnt_d = flush_cnt_q + 2'd1;
                end
            end
            ST_HARM: begin
                // Out-of-range harmonics finish in one cycle with no read.
                if (slot_skip_s || (hw_q == LAT_LAST)) begin
                    for (int i = 0; i < N_PEAKS; i++) begin
                        if (3'(i) == hidx_q) begin
                            list_sin_d[i] = harm_sin_s;
                        end else begin
                            list_sin_d[i] = list_sin_q[i];
                        end
                    end
                    hw_d = 2'd0;
                    if ((hidx_q + 3'd1) >= list_cnt_q) begin
                        state_d = ST_DONE;
                    end else begin
                        hidx_d = hidx_q + 3'd1;
                        if (next_h_s < HALF_H) begin
                            rd_addr_d = next_h_s[ADDR_W-1:0];
                        end else begin
                            rd_addr_d = rd_addr_q;
                        end
                    end
                end else begin
                    hw_d = hw_q + 2'd1;
                end
            end
            ST_DONE: begin
                peak_bin_d = list_bin_q;
                peak_mag_d = list_mag_q;
                peak_sin_d = list_sin_q;
                peak_cnt_d = list_cnt_q;
                valid_d    = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // clr overrides everything, including a coincident start edge.
        if (clr) begin
            state_d     = ST_IDLE;
            rd_addr_d   = '0;
            tag_vld_d   = '0;
            prev_d      = '0;
            cur_d       = '0;
            flush_cnt_d = 2'd0;
            list_bin_d  = '0;
            list_mag_d  = '0;
            list_sin_d  = '0;
            list_cnt_d  = 3'd0;
            hidx_d      = 3'd0;
            hw_d        = 2'd0;
            peak_bin_d  = '0;
            peak_mag_d  = '0;
            peak_sin_d  = '0;
            peak_cnt_d  = 3'd0;
            busy_d      = 1'b0;
            valid_d     = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            start_d_q   <= 1'b0;
            rd_addr_q   <= '0;
            tag_vld_q   <= '0;
            for (int j = 0; j < RD_LAT; j++) begin
                tag_addr_q[j] <= '0;
            end
            prev_q      <= '0;
            cur_q       <= '0;
            flush_cnt_q <= 2'd0;
            list_bin_q  <= '0;
            list_mag_q  <= '0;
            list_sin_q  <= '0;
            list_cnt_q  <= 3'd0;
            hidx_q      <= 3'd0;
            hw_q        <= 2'd0;
            peak_bin_q  <= '0;
            peak_mag_q  <= '0;
            peak_sin_q  <= '0;
            peak_cnt_q  <= 3'd0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_d_q   <= start_d_d;
            rd_addr_q   <= rd_addr_d;
            tag_vld_q   <= tag_vld_d;
            tag_addr_q  <= tag_addr_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            flush_cnt_q <= flush_cnt_d;
            list_bin_q  <= list_bin_d;
            list_mag_q  <= list_mag_d;
            list_sin_q  <= list_sin_d;
            list_cnt_q  <= list_cnt_d;
            hidx_q      <= hidx_d;
            hw_q        <= hw_d;
            peak_bin_q  <= peak_bin_d;
            peak_mag_q  <= peak_mag_d;
            peak_sin_q  <= peak_sin_d;
            peak_cnt_q  <= peak_cnt_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
        end
    end

    assign rd_addr  = rd_addr_q;
    assign peak_bin = peak_bin_q;
    assign peak_mag = peak_mag_q;
    assign peak_sin = peak_sin_q;
    assign peak_cnt = peak_cnt_q;
    assign busy     = busy_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_spec_peak_finder.sv
// -----------------------------------------------------------------------------
// tb_spec_peak_finder
// Directed and randomized spectra are loaded into a one-cycle-latency RAM
// model; the expected peaks, classification and latency are derived from the
// detection rules by an exhaustive search over the stored spectrum.
// -----------------------------------------------------------------------------
module tb_spec_peak_finder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clr;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic [15:0] peak_bin;
    logic [31:0] peak_mag;
    logic [1:0]  peak_sin;
    logic [2:0]  peak_cnt;
    logic        busy;
    logic        valid;

    logic [15:0] mem [256];

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] exp_bin;
    logic [31:0] exp_mag;
    logic [1:0]  exp_sin;
    int          exp_cnt;
    int          exp_lat;

    always #5 clk = ~clk;

    // Magnitude RAM, one cycle read latency.
    always @(posedge clk) rd_data <= mem[rd_addr];

    spec_peak_finder dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .clr      (clr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .peak_bin (peak_bin),
        .peak_mag (peak_mag),
        .peak_sin (peak_sin),
        .peak_cnt (peak_cnt),
        .busy     (busy),
        .valid    (valid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'd0;
    endtask

    // Reference: list all local maxima, pick the two best (largest magnitude,
    // lowest bin on a tie), classify by third harmonic, derive latency.
    task automatic compute_model();
        int pb[$];
        int pm[$];
        bit taken[256];
        int best;
        int h;
        exp_bin = '0; exp_mag = '0; exp_sin = '0; exp_cnt = 0;
        exp_lat = 1 + 129 + 2 + 1;
        for (int k = 1; k < 128; k++) begin
            if (mem[k] > mem[k-1] && mem[k] >= mem[k+1] && mem[k] >= 16'd64) begin
                pb.push_back(k);
                pm.push_back(int'(mem[k]));
            end
        end
        for (int j = 0; j < 256; j++) taken[j] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            best = -1;
            for (int j = 0; j < pb.size(); j++) begin
                if (!taken[j] && (best < 0 || pm[j] > pm[best] ||
                                  (pm[j] == pm[best] && pb[j] < pb[best]))) best = j;
            end
            if (best >= 0) begin
                taken[best] = 1'b1;
                exp_bin[s*8 +: 8]  = 8'(pb[best]);
                exp_mag[s*16 +: 16] = 16'(pm[best]);
                exp_cnt++;
                h = 3 * pb[best];
                if (h >= 128) begin
                    exp_sin[s] = 1'b1;
                    exp_lat += 1;
                end else begin
                    exp_sin[s] = (int'(mem[h]) > (pm[best] / 32)) ? 1'b0 : 1'b1;
                    exp_lat += 2;
                end
            end
        end
    endtask

    // Launch, wait for valid (bounded), compare against the model.
    // poke > 0 raises start again at that cycle count while busy.
    task automatic run_scan(input string tag, input int poke);
        int lat;
        compute_model();
        @(negedge clk); start = 1'b1;
        @(posedge clk); lat = 1; #1; start = 1'b0;
        check({tag, "_launch_valid"}, 64'(valid), 64'd0);
        check({tag, "_launch_busy"}, 64'(busy), 64'd1);
        while (valid !== 1'b1 && lat < 400) begin
            if (poke > 0 && (lat == poke || lat == poke + 1)) start = (lat == poke);
            else start = 1'b0;
            @(posedge clk); lat++; #1;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_cnt"}, 64'(peak_cnt), 64'(exp_cnt));
        check({tag, "_bin"}, 64'(peak_bin), 64'(exp_bin));
        check({tag, "_mag"}, 64'(peak_mag), 64'(exp_mag));
        check({tag, "_sin"}, 64'(peak_sin), 64'(exp_sin));
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clr = 1'b0;
        clear_mem();
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cnt", 64'(peak_cnt), 64'd0);
        check("rst_addr", 64'(rd_addr), 64'd0);
        check("rst_bin", 64'(peak_bin), 64'd0);
        check("rst_sin", 64'(peak_sin), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two sines.
        clear_mem(); mem[20] = 16'd5000; mem[45] = 16'd3000;
        run_scan("two_sines", 0);
        check("two_sines_expbin", 64'(exp_bin), 64'h2d14);

        // Triangle at 10 (strong harmonic at 30) plus sine at 25.
        clear_mem(); mem[10] = 16'd9000; mem[30] = 16'd1000; mem[25] = 16'd4000;
        run_scan("tri_sine", 0);

        // Equal magnitudes plus a plateau.
        clear_mem(); mem[12] = 16'd2000; mem[40] = 16'd2000; mem[60] = 16'd1500; mem[61] = 16'd1500;
        run_scan("tie", 0);

        // Plateau alone reports its first bin.
        clear_mem(); mem[60] = 16'd1500; mem[61] = 16'd1500;
        run_scan("plateau", 0);

        // Edges: DC ignored, last eligible bin, bin 128 not eligible.
        clear_mem(); mem[0] = 16'd60000; mem[127] = 16'd800; mem[128] = 16'd200;
        run_scan("edges", 0);

        // Everything under threshold, with a second start while busy.
        clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 63));
        run_scan("below_thr", 30);

        // Random spectra with noise floor, spikes and some planted harmonics.
        for (int r = 0; r < 5; r++) begin
            int b;
            clear_mem();
            for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 200));
            for (int s = 0; s < 4; s++) begin
                b = $urandom_range(1, 127);
                mem[b] = 16'($urandom_range(64, 20000));
                if (3 * b < 256 && $urandom_range(0, 1) == 1) mem[3*b] = 16'($urandom_range(0, 1500));
            end
            run_scan($sformatf("rand%0d", r), 0);
        end

        // clr mid-scan clears posted results; clr beats a coincident start edge.
        clear_mem(); mem[20] = 16'd5000; mem[45] = 16'd3000;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (39) @(posedge clk);
        @(negedge clk); clr = 1'b1;
        @(posedge clk); #1;
        check("clr_valid", 64'(valid), 64'd0);
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_cnt", 64'(peak_cnt), 64'd0);
        check("clr_bin", 64'(peak_bin), 64'd0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); clr = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("clr_start_lost", 64'(busy), 64'd0);
        @(negedge clk); start = 1'b0;
        run_scan("after_clr", 0);

        // Reset in the harmonic pass.
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (133) @(posedge clk);
        #2; rst = 1'b1; #1;
        check("rst_harm_valid", 64'(valid), 64'd0);
        check("rst_harm_busy", 64'(busy), 64'd0);
        check("rst_harm_cnt", 64'(peak_cnt), 64'd0);
        check("rst_harm_bin", 64'(peak_bin), 64'd0);
        check("rst_harm_mag", 64'(peak_mag), 64'd0);
        check("rst_harm_addr", 64'(rd_addr), 64'd0);
        @(negedge clk); rst = 1'b0;
        repeat (10) @(posedge clk); #1;
        check("rst_idle_valid", 64'(valid), 64'd0);
        check("rst_idle_busy", 64'(busy), 64'd0);
        run_scan("after_rst", 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
